// File: rtl/encoder_16_4_req.sv
// encoder_16_4_req: turns 16 active-low request lines back into a 4-bit index.
// Falling edges on req_n latch into pending bits. The lowest pending index is
// presented on a valid/ready handshake, and its bit is cleared on acceptance.
// Optional build macro ENCODER_16_4_REQ_OVERFLOW_DETECT_EN enables the sticky
// drop flag, which records events merged into an already-pending bit.
module encoder_16_4_req #(
  parameter int N      = 16,
  parameter int CODE_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [N-1:0]      req_n,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  input  logic              ready,
  output logic [N-1:0]      pending,
  output logic              drop
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t              state;
  state_t              state_next;
  logic [CODE_W-1:0]   code_next;
  logic [N-1:0]        req_q;
  logic [N-1:0]        fall;
  logic [N-1:0]        set;
  logic [N-1:0]        clr;
  logic [N-1:0]        cand;
  logic                hs;

  // Lowest set index wins; returns 0 for an empty vector.
  function automatic logic [CODE_W-1:0] prio(input logic [N-1:0] vec);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

  // Edge detect, capture gating, and the next-cycle pending vector.
  always_comb begin
    fall = req_q & ~req_n;
    set  = en ? fall : '0;
    hs   = (state == PRESENT) && ready;
    clr  = hs ? ({{(N-1){1'b0}}, 1'b1} << code) : '0;
    cand = (pending & ~clr) | set;
  end

  // State, code, pending and previous-request registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      code    <= '0;
      pending <= '0;
      req_q   <= '1;
    end else begin
      state   <= state_next;
      code    <= code_next;
      pending <= cand;
      req_q   <= req_n;
    end
  end

  // Next-state and next-code selection; a presented code is never pre-empted.
  always_comb begin
    state_next = state;
    code_next  = code;
    case (state)
      IDLE: begin
        if (pending != '0) begin
          code_next  = prio(pending);
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (hs) begin
          if (cand != '0) begin
            code_next  = prio(cand);
            state_next = PRESENT;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake valid follows the state directly.
  always_comb begin
    valid = (state == PRESENT);
  end

`ifdef ENCODER_16_4_REQ_OVERFLOW_DETECT_EN
  // Sticky flag for a fall landing on a bit that stays pending this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop <= 1'b0;
    end else if ((set & pending & ~clr) != '0) begin
      drop <= 1'b1;
    end
  end
`else
  assign drop = 1'b0;
`endif

endmodule
